// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg
//   Shared definitions for the ID/EX operand stage: the ALU ctrl code the stage
//   resets/flushes to, and the forwarding-select encoding reported by each
//   operand mux.
package id_ex_operand_stage_pkg;

    // ALU control codes (only AND is needed by this stage: the bubble value)
    localparam logic [3:0] ALU_AND = 4'b0000;

    // Which source an operand was taken from
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,   // registered operand
        FWD_EXM  = 2'd1,   // EX/MEM ALU result
        FWD_WB   = 2'd2    // MEM/WB write-back data
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if
//   Bundles every non-clock signal of the ID/EX operand stage.
//   master : decode / hazard unit / later pipeline stages / ALU side (testbench)
//   slave  : the stage itself
//   Groups: dec_* (decoded instruction), stall/flush, exm_* and wb_* (forwarding
//   sources and write-through), ALU-facing outputs, load_use back to decode,
//   fwd_*_sel (debug view of the forwarding choice).
interface id_ex_operand_stage_if
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          dec_valid_i;
    logic [AW-1:0] dec_rs_addr_i;
    logic [AW-1:0] dec_rt_addr_i;
    logic [AW-1:0] dec_rd_addr_i;
    logic [DW-1:0] dec_rs_data_i;
    logic [DW-1:0] dec_rt_data_i;
    logic [DW-1:0] dec_imm_i;
    logic [4:0]    dec_shamt_i;
    logic [3:0]    dec_alu_ctrl_i;
    logic          dec_alusrc_i;
    logic          dec_regwrite_i;
    logic          dec_memread_i;
    logic          dec_uses_rt_i;
    logic          stall_i;
    logic          flush_i;
    logic          exm_regwrite_i;
    logic [AW-1:0] exm_rd_i;
    logic [DW-1:0] exm_result_i;
    logic          wb_regwrite_i;
    logic [AW-1:0] wb_rd_i;
    logic [DW-1:0] wb_data_i;

    logic [DW-1:0] src1_o;
    logic [DW-1:0] src2_o;
    logic [4:0]    shamt_o;
    logic [3:0]    ctrl_o;
    logic [DW-1:0] store_data_o;
    logic [AW-1:0] rd_o;
    logic          regwrite_o;
    logic          memread_o;
    logic          valid_o;
    logic          load_use_o;
    fwd_sel_e      fwd_rs_sel;
    fwd_sel_e      fwd_rt_sel;

    modport master (
        output dec_valid_i, dec_rs_addr_i, dec_rt_addr_i, dec_rd_addr_i,
               dec_rs_data_i, dec_rt_data_i, dec_imm_i, dec_shamt_i,
               dec_alu_ctrl_i, dec_alusrc_i, dec_regwrite_i, dec_memread_i,
               dec_uses_rt_i, stall_i, flush_i,
               exm_regwrite_i, exm_rd_i, exm_result_i,
               wb_regwrite_i, wb_rd_i, wb_data_i,
        input  src1_o, src2_o, shamt_o, ctrl_o, store_data_o, rd_o,
               regwrite_o, memread_o, valid_o, load_use_o,
               fwd_rs_sel, fwd_rt_sel
    );

    modport slave (
        input  dec_valid_i, dec_rs_addr_i, dec_rt_addr_i, dec_rd_addr_i,
               dec_rs_data_i, dec_rt_data_i, dec_imm_i, dec_shamt_i,
               dec_alu_ctrl_i, dec_alusrc_i, dec_regwrite_i, dec_memread_i,
               dec_uses_rt_i, stall_i, flush_i,
               exm_regwrite_i, exm_rd_i, exm_result_i,
               wb_regwrite_i, wb_rd_i, wb_data_i,
        output src1_o, src2_o, shamt_o, ctrl_o, store_data_o, rd_o,
               regwrite_o, memread_o, valid_o, load_use_o,
               fwd_rs_sel, fwd_rt_sel
    );
endinterface

// File: rtl/id_ex_operand_stage_fwd.sv
// operand_fwd_mux
//   Picks the freshest value of one source register for the ALU.
//   EX/MEM beats MEM/WB; register 0 is never forwarded.
//   Ports: addr/data   registered operand index and value
//          exm_*       EX/MEM destination and result
//          wb_*        MEM/WB destination and data
//          q           selected operand
//          sel         which source was chosen (debug)
module operand_fwd_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          exm_regwrite,
    input  logic [AW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] q,
    output fwd_sel_e      sel
);
    always_comb begin
        q   = data;
        sel = FWD_NONE;
        if (addr != '0) begin
            if (exm_regwrite && exm_rd == addr) begin
                q   = exm_result;
                sel = FWD_EXM;
            end else if (wb_regwrite && wb_rd == addr) begin
                q   = wb_data;
                sel = FWD_WB;
            end
        end
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register feeding the ALU. Captures decoded operands with
//   MEM/WB write-through, forwards EX/MEM and MEM/WB results onto the
//   registered operands, and flags load-use hazards back to decode.
//   Ports: clk_i  rising-edge clock
//          rst_i  asynchronous reset, active low
//          bus    id_ex_operand_stage_if.slave (all other signals)
//   Update priority: flush (bubble) > stall (hold) > load.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    id_ex_operand_stage_if.slave  bus
);
    logic          valid_q, alusrc_q, regwrite_q, memread_q;
    logic [AW-1:0] rs_q, rt_q, rd_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0]    shamt_q;
    logic [3:0]    ctrl_q;

    // Register file is written and read in the same cycle: take the value
    // being written instead of the stale read.
    logic          wb_hit_rs, wb_hit_rt;
    logic [DW-1:0] rs_cap, rt_cap;

    assign wb_hit_rs = bus.wb_regwrite_i && (bus.wb_rd_i != '0) && (bus.wb_rd_i == bus.dec_rs_addr_i);
    assign wb_hit_rt = bus.wb_regwrite_i && (bus.wb_rd_i != '0) && (bus.wb_rd_i == bus.dec_rt_addr_i);
    assign rs_cap    = wb_hit_rs ? bus.wb_data_i : bus.dec_rs_data_i;
    assign rt_cap    = wb_hit_rt ? bus.wb_data_i : bus.dec_rt_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            ctrl_q     <= ALU_AND;
        end else if (bus.flush_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            ctrl_q     <= ALU_AND;
        end else if (!bus.stall_i) begin
            valid_q    <= bus.dec_valid_i;
            regwrite_q <= bus.dec_regwrite_i && bus.dec_valid_i;
            memread_q  <= bus.dec_memread_i && bus.dec_valid_i;
            alusrc_q   <= bus.dec_alusrc_i;
            rs_q       <= bus.dec_rs_addr_i;
            rt_q       <= bus.dec_rt_addr_i;
            rd_q       <= bus.dec_rd_addr_i;
            rs_data_q  <= rs_cap;
            rt_data_q  <= rt_cap;
            imm_q      <= bus.dec_imm_i;
            shamt_q    <= bus.dec_shamt_i;
            ctrl_q     <= bus.dec_alu_ctrl_i;
        end
    end

    logic [DW-1:0] rs_fwd, rt_fwd;

    operand_fwd_mux #(.AW(AW), .DW(DW)) u_fwd_rs (
        .addr         (rs_q),
        .data         (rs_data_q),
        .exm_regwrite (bus.exm_regwrite_i),
        .exm_rd       (bus.exm_rd_i),
        .exm_result   (bus.exm_result_i),
        .wb_regwrite  (bus.wb_regwrite_i),
        .wb_rd        (bus.wb_rd_i),
        .wb_data      (bus.wb_data_i),
        .q            (rs_fwd),
        .sel          (bus.fwd_rs_sel)
    );

    operand_fwd_mux #(.AW(AW), .DW(DW)) u_fwd_rt (
        .addr         (rt_q),
        .data         (rt_data_q),
        .exm_regwrite (bus.exm_regwrite_i),
        .exm_rd       (bus.exm_rd_i),
        .exm_result   (bus.exm_result_i),
        .wb_regwrite  (bus.wb_regwrite_i),
        .wb_rd        (bus.wb_rd_i),
        .wb_data      (bus.wb_data_i),
        .q            (rt_fwd),
        .sel          (bus.fwd_rt_sel)
    );

    assign bus.src1_o       = rs_fwd;
    assign bus.store_data_o = rt_fwd;
    assign bus.src2_o       = alusrc_q ? imm_q : rt_fwd;
    assign bus.shamt_o      = shamt_q;
    assign bus.ctrl_o       = ctrl_q;
    assign bus.rd_o         = rd_q;
    assign bus.valid_o      = valid_q;
    // Already gated at capture; the extra AND keeps them low on any path
    // that leaves valid clear.
    assign bus.regwrite_o   = regwrite_q && valid_q;
    assign bus.memread_o    = memread_q && valid_q;

    // Load in this stage whose destination the instruction in decode reads.
    // Independent of stall/flush: the hazard unit owns that reaction.
    assign bus.load_use_o = valid_q && memread_q && (rd_q != '0) &&
                            ((rd_q == bus.dec_rs_addr_i) ||
                             (bus.dec_uses_rt_i && (rd_q == bus.dec_rt_addr_i)));
endmodule
